ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Arbiter end of the master request interface: samples per-master hbusreq/hlock and drives one-hot hgrant, the 4-bit hmaster owner index and hmastlock.
- Sits between the NUM_MASTERS master agents and the shared AHB address/data mux; hmaster selects the mux.
- Fixed priority: master 0 is highest. Honours locked sequences with a one-transfer lock tail. Re-arbitrates only on cycles where hready=1.

Parameters:
NUM_MASTERS, 4, number of masters; legal range 1..16 (hmaster is 4 bits)
DEFAULT_MASTER, 0, index granted when no master requests; must be < NUM_MASTERS

Ports:
hclk  input  1  bus clock; all logic on rising edge
hreset  input  1  reset, synchronous, active-low
hbusreq  input  NUM_MASTERS  per-master bus request
hlock  input  NUM_MASTERS  per-master locked-transfer request
hready  input  1  transfer-done from slave mux; gates all grant/owner updates
hgrant  output  NUM_MASTERS  one-hot grant, registered
hmaster  output  4  index of current address-phase owner, registered
hmastlock  output  1  current owner's transfer is locked, registered

Behaviour:
- Reset (hreset=0 at a rising edge, including mid-transfer): hgrant=1<<DEFAULT_MASTER, hmaster=DEFAULT_MASTER, hmastlock=0, state=OPEN. No other reset values exist.
- hready=0 at an edge: hgrant, hmaster, hmastlock and state all hold, however many cycles it lasts.
- Owner register: at every edge with hready=1:
  - hmaster <= index of the current (pre-update) hgrant.
  - hmastlock <= hlock[that index] AND hbusreq[that index].
  - So hmaster changes exactly one cycle after the edge where the new hgrant and hready=1 are both sampled.
- Grant update: at an edge with hready=1, next hgrant is chosen by the FSM below. Let g = the currently granted index.
- OPEN:
  - If hlock[g]=1 and hbusreq[g]=1: keep g and go to LOCKED.
  - Otherwise grant the lowest-index master with hbusreq=1. If none requests, grant DEFAULT_MASTER.
- LOCKED:
  - While hlock[g]=1 and hbusreq[g]=1: keep g, even if a higher-priority master requests.
  - Otherwise keep g one more hready cycle and go to LOCK_TAIL.
- LOCK_TAIL: perform a normal OPEN arbitration and go to OPEN. If the resulting grant has hlock=1 and hbusreq=1, go to LOCKED instead.
- hlock without hbusreq on the same master is ignored: no lock, and hmastlock=0.
- Simultaneous events: an active lock beats any higher-priority request. Reset beats everything.
- hgrant is always exactly one-hot; an all-zero hgrant is never legal.
- Index encoding: hmaster upper bits are zero when NUM_MASTERS < 16.
- Latency: request to hgrant is 1 cycle once hready=1. Request to hmaster is 2 cycles.

Test Plan:
- Idle default: NUM_MASTERS=4, DEFAULT_MASTER=0, hreset low 2 cycles then high, hbusreq=0, hready=1 -> hgrant=4'b0001, hmaster=0, hmastlock=0 for all cycles.
- Priority: hbusreq=4'b1010 with hready=1 -> hgrant=4'b0010 at the next edge, hmaster=1 one edge later. Then drop hbusreq[1] -> hgrant=4'b1000 next edge, hmaster=3 one edge after that.
- hready stall: master 2 requests while hready=0 for 5 cycles -> hgrant and hmaster frozen. hready rises -> hgrant=4'b0100 at that edge, hmaster=2 at the following hready edge.
- Lock hold and tail:
  - Master 3 is granted with hlock[3]=1, then hbusreq[0] rises -> hgrant stays 4'b1000 and hmastlock=1 while the lock holds.
  - Drop hlock[3] -> 4'b1000 for exactly one more hready cycle, then 4'b0001.
- Lock without request: hlock[2]=1 with hbusreq[2]=0 -> no LOCKED entry, hmastlock stays 0, normal priority grant.
- Mid-operation reset: in LOCKED with hgrant=4'b1000, hreset=0 for one edge -> hgrant=4'b0001, hmaster=0, hmastlock=0, state OPEN at that edge.

Source files
------------

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant signal bundle between the AHB masters and the bus arbiter.
// The master modport is the arbiter side (it drives the grants); slave is the requester side.
interface ahb_bus_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 4
);
   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic                   hready;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [3:0]             hmaster;
   logic                   hmastlock;

   modport master (
      input  hbusreq,
      input  hlock,
      input  hready,
      output hgrant,
      output hmaster,
      output hmastlock
   );

   modport slave (
      output hbusreq,
      output hlock,
      output hready,
      input  hgrant,
      input  hmaster,
      input  hmastlock
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Fixed-priority AHB bus arbiter (master 0 highest) with locked-sequence hold and a
// one-transfer lock tail; grant and owner registers only advance on hready cycles.
module ahb_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned DEFAULT_MASTER = 0
) (
   input  logic              hclk,
   input  logic              hreset,
   ahb_bus_arbiter_if.master bus
);

   localparam logic [1:0] ST_OPEN      = 2'd0;
   localparam logic [1:0] ST_LOCKED    = 2'd1;
   localparam logic [1:0] ST_LOCK_TAIL = 2'd2;

   localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [NUM_MASTERS-1:0] w_grant_nxt;
   logic [NUM_MASTERS-1:0] w_prio_grant;
   logic [3:0]             r_master;
   logic                   r_mastlock;
   logic [3:0]             w_grant_idx;
   logic                   w_own_lock;
   logic                   w_prio_lock;

   // Lowest-index requester wins; the default master is parked on when nobody asks.
   always_comb begin
      w_prio_grant = DEFAULT_GRANT;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (bus.hbusreq[i]) begin
            w_prio_grant = NUM_MASTERS'(1) << i;
         end
      end
   end

   always_comb begin
      w_grant_idx = 4'd0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_grant[i]) begin
            w_grant_idx = w_grant_idx | 4'(i);
         end
      end
   end

   // A lock only counts when the same master is also requesting.
   assign w_own_lock  = |(bus.hlock & bus.hbusreq & r_grant);
   assign w_prio_lock = |(bus.hlock & bus.hbusreq & w_prio_grant);

   always_comb begin
      w_grant_nxt = r_grant;
      w_state_nxt = r_state;
      case (r_state)
         ST_OPEN: begin
            if (w_own_lock) begin
               w_state_nxt = ST_LOCKED;
            end else begin
               w_grant_nxt = w_prio_grant;
            end
         end
         ST_LOCKED: begin
            if (!w_own_lock) begin
               w_state_nxt = ST_LOCK_TAIL;
            end
         end
         ST_LOCK_TAIL: begin
            w_grant_nxt = w_prio_grant;
            w_state_nxt = w_prio_lock ? ST_LOCKED : ST_OPEN;
         end
         default: begin
            w_grant_nxt = DEFAULT_GRANT;
            w_state_nxt = ST_OPEN;
         end
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hreset) begin
         r_state    <= ST_OPEN;
         r_grant    <= DEFAULT_GRANT;
         r_master   <= 4'(DEFAULT_MASTER);
         r_mastlock <= 1'b0;
      end else if (bus.hready) begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_master   <= w_grant_idx;
         r_mastlock <= w_own_lock;
      end
   end

   assign bus.hgrant    = r_grant;
   assign bus.hmaster   = r_master;
   assign bus.hmastlock = r_mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Randomized and directed bench for ahb_bus_arbiter against a behavioural
// model of the grant/lock rules.
module tb_ahb_bus_arbiter;

   localparam int N   = 4;
   localparam int DEF = 0;

   logic hclk;
   logic hreset;
   int   errors;
   int   checks;

   ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

   ahb_bus_arbiter #(
      .NUM_MASTERS   (N),
      .DEFAULT_MASTER(DEF)
   ) dut (
      .hclk  (hclk),
      .hreset(hreset),
      .bus   (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Model: owner index, owner lock flag, and where we are in a locked sequence.
   int m_g;
   int m_master;
   bit m_mastlock;
   bit m_in_lock;
   bit m_tail_due;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int prio_pick(input logic [N-1:0] req);
      for (int i = 0; i < N; i++) begin
         if (req[i]) return i;
      end
      return DEF;
   endfunction

   task automatic model_edge();
      bit own;
      int p;
      if (!hreset) begin
         m_g = DEF; m_master = DEF; m_mastlock = 0; m_in_lock = 0; m_tail_due = 0;
      end else if (bus.hready) begin
         own        = bus.hlock[m_g] && bus.hbusreq[m_g];
         m_master   = m_g;
         m_mastlock = own;
         if (m_in_lock) begin
            if (!own) begin
               m_in_lock  = 0;
               m_tail_due = 1;
            end
         end else if (m_tail_due) begin
            m_tail_due = 0;
            p          = prio_pick(bus.hbusreq);
            m_g        = p;
            m_in_lock  = bus.hlock[p] && bus.hbusreq[p];
         end else if (own) begin
            m_in_lock = 1;
         end else begin
            m_g = prio_pick(bus.hbusreq);
         end
      end
   endtask

   // Advance one clock: model uses pre-edge inputs, DUT sampled 1 time unit after the edge.
   task automatic tick();
      model_edge();
      @(posedge hclk);
      #1;
      check_eq("hgrant", 32'(bus.hgrant), 32'(1 << m_g));
      check_eq("hmaster", 32'(bus.hmaster), 32'(m_master));
      check_eq("hmastlock", 32'(bus.hmastlock), 32'(m_mastlock));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      hreset = 1'b0;
      bus.hbusreq = '0;
      bus.hlock   = '0;
      bus.hready  = 1'b1;
      m_g = DEF; m_master = DEF; m_mastlock = 0; m_in_lock = 0; m_tail_due = 0;

      // Idle default
      ticks(2);
      check_eq("reset_grant", 32'(bus.hgrant), 32'h1);
      hreset = 1'b1;
      ticks(3);
      check_eq("idle_grant", 32'(bus.hgrant), 32'h1);
      check_eq("idle_master", 32'(bus.hmaster), 32'h0);

      // Priority
      bus.hbusreq = 4'b1010;
      tick();
      check_eq("prio_grant1", 32'(bus.hgrant), 32'h2);
      tick();
      check_eq("prio_master1", 32'(bus.hmaster), 32'h1);
      bus.hbusreq = 4'b1000;
      tick();
      check_eq("prio_grant3", 32'(bus.hgrant), 32'h8);
      tick();
      check_eq("prio_master3", 32'(bus.hmaster), 32'h3);

      // hready stall
      bus.hbusreq = 4'b0100;
      bus.hready  = 1'b0;
      ticks(5);
      check_eq("stall_grant", 32'(bus.hgrant), 32'h8);
      check_eq("stall_master", 32'(bus.hmaster), 32'h3);
      bus.hready = 1'b1;
      tick();
      check_eq("unstall_grant", 32'(bus.hgrant), 32'h4);
      tick();
      check_eq("unstall_master", 32'(bus.hmaster), 32'h2);

      // Lock hold and tail
      bus.hbusreq = 4'b1000;
      bus.hlock   = 4'b1000;
      ticks(2);
      bus.hbusreq = 4'b1001;
      ticks(3);
      check_eq("lock_hold_grant", 32'(bus.hgrant), 32'h8);
      check_eq("lock_hold_mastlock", 32'(bus.hmastlock), 32'h1);
      bus.hlock = 4'b0000;
      tick();
      check_eq("lock_tail_grant", 32'(bus.hgrant), 32'h8);
      tick();
      check_eq("lock_release_grant", 32'(bus.hgrant), 32'h1);

      // Lock without request
      bus.hbusreq = 4'b0010;
      bus.hlock   = 4'b0100;
      ticks(3);
      check_eq("nolock_grant", 32'(bus.hgrant), 32'h2);
      check_eq("nolock_mastlock", 32'(bus.hmastlock), 32'h0);

      // Mid-operation reset while locked
      bus.hbusreq = 4'b1000;
      bus.hlock   = 4'b1000;
      ticks(3);
      check_eq("prereset_grant", 32'(bus.hgrant), 32'h8);
      hreset = 1'b0;
      tick();
      check_eq("midreset_grant", 32'(bus.hgrant), 32'h1);
      check_eq("midreset_master", 32'(bus.hmaster), 32'h0);
      check_eq("midreset_mastlock", 32'(bus.hmastlock), 32'h0);
      hreset = 1'b1;
      bus.hbusreq = '0;
      bus.hlock   = '0;
      tick();

      // Random traffic, locks biased to persist so LOCKED/LOCK_TAIL get exercised
      for (int c = 0; c < 600; c++) begin
         bus.hbusreq = N'($urandom);
         if ($urandom_range(0, 3) == 0) bus.hlock = N'($urandom);
         bus.hready = ($urandom_range(0, 3) != 0);
         hreset     = ($urandom_range(0, 99) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
